// File: rtl/alu_seq_param.sv
// -----------------------------------------------------------------------------
// alu_seq_param
// Registered, handshaked ALU sitting between operand fetch and writeback.
// One operation is accepted per in_valid/in_ready handshake; the result and
// flags are returned registered with out_valid/out_ready back-pressure.
//
// Optional feature macro: ALU_SEQ_MUL_EN
//   defined   : arith opcode 7 is a WIDTH-cycle shift-add multiply (CALC state)
//   undefined : no multiplier hardware; arith opcode 7 is a reserved opcode
//
// Parameters
//   WIDTH      operand/result width (power of 2, >= 4)
// Ports
//   clk        rising-edge clock
//   rst_n      asynchronous active-low reset
//   in_valid   operation valid          in_ready  operation can be accepted
//   a, b       operands                 alu_sel   opcode (8..15 reserved)
//   m          1 = logic, 0 = arith     cin       carry-in for arith opcode 0
//   out_valid  result valid             out_ready consumer takes result
//   f          result                   cout      carry / MUL high half nonzero
//   ovf        signed overflow          zero      f == 0
//   eq         captured a == b          err       reserved/disabled opcode
// -----------------------------------------------------------------------------
module alu_seq_param #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             in_valid,
  output logic             in_ready,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic [3:0]       alu_sel,
  input  logic             m,
  input  logic             cin,
  output logic             out_valid,
  input  logic             out_ready,
  output logic [WIDTH-1:0] f,
  output logic             cout,
  output logic             ovf,
  output logic             zero,
  output logic             eq,
  output logic             err
);

  localparam int SW = $clog2(WIDTH);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
`ifdef ALU_SEQ_MUL_EN
    CALC = 2'd1,
`endif
    DONE = 2'd2
  } state_t;

  state_t           state_r;
  state_t           state_next_s;
  state_t           start_state_s;
  logic             accept_s;
  logic             is_mul_s;
  logic             mul_last_s;
  logic [WIDTH-1:0] mul_f_s;
  logic             mul_cout_s;
  logic             mul_eq_s;

  logic [WIDTH-1:0] op_b_s;
  logic             carry_s;
  logic [WIDTH:0]   sum_s;
  logic [SW-1:0]    sh_s;
  logic [WIDTH-1:0] res_f_s;
  logic             res_cout_s;
  logic             res_ovf_s;
  logic             res_err_s;
  logic             res_zero_s;
  logic             eq_s;

  // Handshake: ready when idle, or when the held result retires this edge.
  always_comb begin
    in_ready = (state_r == IDLE) || ((state_r == DONE) && out_ready);
    accept_s = in_valid && in_ready;
  end

`ifdef ALU_SEQ_MUL_EN
  logic [WIDTH-1:0]   mcand_r;
  logic [2*WIDTH-1:0] acc_r;
  logic [2*WIDTH-1:0] acc_next_s;
  logic [WIDTH:0]     hi_sum_s;
  logic [SW-1:0]      cnt_r;
  logic               eq_pend_r;

  // Multiply decode and one shift-add step. The low half of the accumulator
  // starts as the multiplier and is shifted out as the product shifts in.
  always_comb begin
    is_mul_s = (m == 1'b0) && (alu_sel == 4'd7);
    if (is_mul_s) begin
      start_state_s = CALC;
    end else begin
      start_state_s = DONE;
    end
    hi_sum_s   = {1'b0, acc_r[2*WIDTH-1:WIDTH]}
               + (acc_r[0] ? {1'b0, mcand_r} : {(WIDTH+1){1'b0}});
    acc_next_s = {hi_sum_s, acc_r[WIDTH-1:1]};
    mul_last_s = (state_r == CALC) && (cnt_r == {SW{1'b0}});
    mul_f_s    = acc_next_s[WIDTH-1:0];
    mul_cout_s = |acc_next_s[2*WIDTH-1:WIDTH];
    mul_eq_s   = eq_pend_r;
  end

  // Multiplier operand capture, iteration counter and accumulator.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mcand_r   <= {WIDTH{1'b0}};
      acc_r     <= {(2*WIDTH){1'b0}};
      cnt_r     <= {SW{1'b0}};
      eq_pend_r <= 1'b0;
    end else if (accept_s && is_mul_s) begin
      mcand_r   <= a;
      acc_r     <= {{WIDTH{1'b0}}, b};
      cnt_r     <= SW'(WIDTH - 1);
      eq_pend_r <= (a == b);
    end else if (state_r == CALC) begin
      acc_r <= acc_next_s;
      cnt_r <= cnt_r - {{(SW-1){1'b0}}, 1'b1};
    end else begin
      acc_r <= acc_r;
      cnt_r <= cnt_r;
    end
  end
`else
  // Multiplier absent: opcode 7 falls through to the reserved-opcode path.
  always_comb begin
    is_mul_s      = 1'b0;
    start_state_s = DONE;
    mul_last_s    = 1'b0;
    mul_f_s       = {WIDTH{1'b0}};
    mul_cout_s    = 1'b0;
    mul_eq_s      = 1'b0;
  end
`endif

  // Adder operand select: B, ~B+1, +1 and +all-ones share one WIDTH+1 adder.
  always_comb begin
    op_b_s  = b;
    carry_s = 1'b0;
    case (alu_sel[1:0])
      2'd0: begin op_b_s = b;                           carry_s = cin;  end
      2'd1: begin op_b_s = ~b;                          carry_s = 1'b1; end
      2'd2: begin op_b_s = {{(WIDTH-1){1'b0}}, 1'b1};   carry_s = 1'b0; end
      2'd3: begin op_b_s = {WIDTH{1'b1}};               carry_s = 1'b0; end
      default: begin op_b_s = b;                        carry_s = 1'b0; end
    endcase
    sum_s = {1'b0, a} + {1'b0, op_b_s} + {{WIDTH{1'b0}}, carry_s};
    sh_s  = b[SW-1:0];
  end

  // Single-cycle result and flags from the live operands (registered on accept).
  always_comb begin
    res_f_s    = {WIDTH{1'b0}};
    res_cout_s = 1'b0;
    res_ovf_s  = 1'b0;
    res_err_s  = 1'b0;
    if (alu_sel[3]) begin
      res_err_s = 1'b1;
    end else if (m) begin
      case (alu_sel[2:0])
        3'd0:    res_f_s = ~a;
        3'd1:    res_f_s = a & b;
        3'd2:    res_f_s = a | b;
        3'd3:    res_f_s = a ^ b;
        3'd4:    res_f_s = ~(a & b);
        3'd5:    res_f_s = ~(a | b);
        3'd6:    res_f_s = ~(a ^ b);
        3'd7:    res_f_s = b;
        default: res_f_s = {WIDTH{1'b0}};
      endcase
    end else begin
      case (alu_sel[2:0])
        3'd0, 3'd1, 3'd2, 3'd3: begin
          res_f_s    = sum_s[WIDTH-1:0];
          res_cout_s = sum_s[WIDTH];
          // Overflow: like-signed operands producing an opposite-signed sum.
          res_ovf_s  = (a[WIDTH-1] == op_b_s[WIDTH-1]) && (sum_s[WIDTH-1] != a[WIDTH-1]);
        end
        3'd4:    res_f_s = a << sh_s;
        3'd5:    res_f_s = a >> sh_s;
        3'd6:    res_f_s = $signed(a) >>> sh_s;
        3'd7:    res_err_s = 1'b1;
        default: res_err_s = 1'b1;
      endcase
    end
    res_zero_s = (res_f_s == {WIDTH{1'b0}});
    eq_s       = (a == b);
  end

  // FSM state register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (accept_s) begin
          state_next_s = start_state_s;
        end else begin
          state_next_s = IDLE;
        end
      end
`ifdef ALU_SEQ_MUL_EN
      CALC: begin
        if (cnt_r == {SW{1'b0}}) begin
          state_next_s = DONE;
        end else begin
          state_next_s = CALC;
        end
      end
`endif
      DONE: begin
        if (out_ready && accept_s) begin
          state_next_s = start_state_s;
        end else if (out_ready) begin
          state_next_s = IDLE;
        end else begin
          state_next_s = DONE;
        end
      end
      default: state_next_s = IDLE;
    endcase
  end

  // Output registers: load on 1-cycle accept or MUL completion, hold otherwise.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      out_valid <= 1'b0;
      f         <= {WIDTH{1'b0}};
      cout      <= 1'b0;
      ovf       <= 1'b0;
      zero      <= 1'b0;
      eq        <= 1'b0;
      err       <= 1'b0;
    end else if (accept_s && !is_mul_s) begin
      out_valid <= 1'b1;
      f         <= res_f_s;
      cout      <= res_cout_s;
      ovf       <= res_ovf_s;
      zero      <= res_zero_s;
      eq        <= eq_s;
      err       <= res_err_s;
    end else if (mul_last_s) begin
      out_valid <= 1'b1;
      f         <= mul_f_s;
      cout      <= mul_cout_s;
      ovf       <= 1'b0;
      zero      <= (mul_f_s == {WIDTH{1'b0}});
      eq        <= mul_eq_s;
      err       <= 1'b0;
    end else if (accept_s) begin
      // MUL started: previous result retires, new one arrives after CALC.
      out_valid <= 1'b0;
    end else if (out_valid && out_ready) begin
      out_valid <= 1'b0;
    end else begin
      out_valid <= out_valid;
    end
  end

endmodule

// File: tb/tb_alu_seq_param.sv
// -----------------------------------------------------------------------------
// tb_alu_seq_param
// Self-checking bench for alu_seq_param (WIDTH=16). A cycle-level model derived
// from the arithmetic definition of each opcode predicts in_ready, out_valid and
// the result/flags; a compare process checks them every cycle. Directed vectors
// with hand-computed literals pin the key scenarios. Builds with or without
// ALU_SEQ_MUL_EN.
// -----------------------------------------------------------------------------
module tb_alu_seq_param;

  localparam int W = 16;

  logic          clk;
  logic          rst_n;
  logic          in_valid;
  logic          in_ready;
  logic [W-1:0]  a;
  logic [W-1:0]  b;
  logic [3:0]    alu_sel;
  logic          m;
  logic          cin;
  logic          out_valid;
  logic          out_ready;
  logic [W-1:0]  f;
  logic          cout;
  logic          ovf;
  logic          zero;
  logic          eq;
  logic          err;

  typedef struct packed {
    logic [W-1:0] f;
    logic         cout;
    logic         ovf;
    logic         zero;
    logic         eq;
    logic         err;
  } res_t;

  int compared   = 0;
  int mismatched = 0;

  alu_seq_param #(.WIDTH(W)) dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .a(a), .b(b), .alu_sel(alu_sel), .m(m), .cin(cin),
    .out_valid(out_valid), .out_ready(out_ready), .f(f), .cout(cout),
    .ovf(ovf), .zero(zero), .eq(eq), .err(err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    compared++;
    if (act !== exp) begin
      mismatched++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // {out_valid, f, cout, ovf, zero, eq, err}
  function automatic logic [21:0] outs();
    return {out_valid, f, cout, ovf, zero, eq, err};
  endfunction

  function automatic bit is_mul_op(input logic [3:0] sel_i, input logic m_i);
`ifdef ALU_SEQ_MUL_EN
    return (m_i == 1'b0) && (sel_i == 4'd7);
`else
    return 1'b0;
`endif
  endfunction

  // Reference result from plain integer arithmetic.
  function automatic res_t exp_calc(input logic [W-1:0] a_i, input logic [W-1:0] b_i,
                                    input logic [3:0] sel_i, input logic m_i, input logic cin_i);
    res_t   r;
    longint lim, smax, smin, ua, ub, sa, sb, full, sres, sh, t;
    r    = '0;
    lim  = longint'(1) << W;
    smax = lim / 2 - 1;
    smin = -(lim / 2);
    ua   = longint'(a_i);
    ub   = longint'(b_i);
    sa   = a_i[W-1] ? ua - lim : ua;
    sb   = b_i[W-1] ? ub - lim : ub;
    sh   = ub % W;
    if (sel_i >= 4'd8) begin
      r.err = 1'b1;
    end else if (m_i) begin
      case (sel_i)
        4'd0: r.f = ~a_i;
        4'd1: r.f = a_i & b_i;
        4'd2: r.f = a_i | b_i;
        4'd3: r.f = a_i ^ b_i;
        4'd4: r.f = ~(a_i & b_i);
        4'd5: r.f = ~(a_i | b_i);
        4'd6: r.f = ~(a_i ^ b_i);
        default: r.f = b_i;
      endcase
    end else begin
      case (sel_i)
        4'd0: begin
          full = ua + ub + longint'(cin_i); r.f = full[W-1:0]; r.cout = full >= lim;
          sres = sa + sb + longint'(cin_i); r.ovf = (sres > smax) || (sres < smin);
        end
        4'd1: begin
          full = ua - ub; r.f = full[W-1:0]; r.cout = ua >= ub;
          sres = sa - sb; r.ovf = (sres > smax) || (sres < smin);
        end
        4'd2: begin
          full = ua + 1; r.f = full[W-1:0]; r.cout = ua == lim - 1; r.ovf = sa + 1 > smax;
        end
        4'd3: begin
          full = ua - 1; r.f = full[W-1:0]; r.cout = ua != 0; r.ovf = sa - 1 < smin;
        end
        4'd4: begin t = ua << sh; r.f = t[W-1:0]; end
        4'd5: begin t = ua >> sh; r.f = t[W-1:0]; end
        4'd6: begin t = sa >>> sh; r.f = t[W-1:0]; end
        default: begin
`ifdef ALU_SEQ_MUL_EN
          full = ua * ub; r.f = full[W-1:0]; r.cout = (full >> W) != 0;
`else
          r.err = 1'b1;
`endif
        end
      endcase
    end
    r.zero = (r.f == '0);
    r.eq   = (a_i == b_i);
    return r;
  endfunction

  // Cycle model: a pending multiply counts down WIDTH edges; a held result
  // stays until taken; a new op is taken whenever nothing blocks it.
  logic m_valid, m_busy;
  int   m_cnt;
  res_t m_res, m_mulres;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_valid <= 1'b0; m_busy <= 1'b0; m_cnt <= 0; m_res <= '0; m_mulres <= '0;
    end else if (m_busy) begin
      m_cnt <= m_cnt - 1;
      if (m_cnt == 1) begin
        m_busy <= 1'b0; m_valid <= 1'b1; m_res <= m_mulres;
      end
    end else if (in_valid && (!m_valid || out_ready)) begin
      if (is_mul_op(alu_sel, m)) begin
        m_busy <= 1'b1; m_cnt <= W; m_valid <= 1'b0;
        m_mulres <= exp_calc(a, b, alu_sel, m, cin);
      end else begin
        m_valid <= 1'b1; m_res <= exp_calc(a, b, alu_sel, m, cin);
      end
    end else if (m_valid && out_ready) begin
      m_valid <= 1'b0;
    end
  end

  // Per-cycle comparison against the model.
  always @(negedge clk) begin
    if (rst_n) begin
      check("in_ready", 64'(in_ready), 64'(!m_busy && (!m_valid || out_ready)));
      check("out_valid", 64'(out_valid), 64'(m_valid));
      if (m_valid) begin
        check("result", 64'({f, cout, ovf, zero, eq, err}), 64'(m_res));
      end
    end
  end

  // Present an op (caller sits just after a rising edge), hold it until accepted.
  task automatic do_op(input logic [W-1:0] av, input logic [W-1:0] bv, input logic [3:0] sv,
                       input logic mv, input logic cv, input bit rnd);
    int n;
    bit done;
    n = 0; done = 1'b0;
    a = av; b = bv; alu_sel = sv; m = mv; cin = cv; in_valid = 1'b1;
    while (!done) begin
      @(negedge clk);
      if (in_ready) begin
        done = 1'b1;
      end else begin
        n++;
        if (n > 100) begin
          compared++; mismatched++;
          $display("FAIL accept_timeout: in_ready=%0b after %0d cycles, expected 1", in_ready, n);
          done = 1'b1;
        end
        @(posedge clk); #1;
        if (rnd) out_ready = ($urandom_range(0, 1) == 1);
      end
    end
    @(posedge clk); #1;
    in_valid = 1'b0;
  endtask

  task automatic to_slot();
    @(posedge clk); #1;
  endtask

  initial begin
    rst_n = 1'b0; in_valid = 1'b0; a = '0; b = '0; alu_sel = '0; m = 1'b0; cin = 1'b0;
    out_ready = 1'b1;
    #1;
    check("reset_outs", 64'(outs()), 64'(0));
    check("reset_in_ready", 64'(in_ready), 64'(1));

    // Pin the model with hand-computed values.
    check("model_sub", 64'(exp_calc(16'h8000, 16'h0001, 4'd1, 1'b0, 1'b0)),
          64'({16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    check("model_dec", 64'(exp_calc(16'h8000, 16'h0000, 4'd3, 1'b0, 1'b0)),
          64'({16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    check("model_asr", 64'(exp_calc(16'h8000, 16'h0004, 4'd6, 1'b0, 1'b0)),
          64'({16'hF800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));

    repeat (3) @(posedge clk);
    #1 rst_n = 1'b1;
    to_slot();

    // Add with carry-out wrapping to zero.
    do_op(16'hFFFF, 16'h0001, 4'd0, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t1_add", 64'(outs()), 64'({1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b0, 1'b0}));
    to_slot();

    // Subtract: signed overflow, then equal operands (back-to-back).
    do_op(16'h8000, 16'h0001, 4'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_sub_ovf", 64'(outs()), 64'({1'b1, 16'h7FFF, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0}));
    to_slot();
    do_op(16'h1234, 16'h1234, 4'd1, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t2_sub_eq", 64'(outs()), 64'({1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0}));
    to_slot();

    // Reserved opcode and arithmetic shift right.
    do_op(16'h1234, 16'h5678, 4'd9, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_reserved", 64'(outs()), 64'({1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}));
    to_slot();
    do_op(16'h8000, 16'h0004, 4'd6, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t6_asr", 64'(outs()), 64'({1'b1, 16'hF800, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
    to_slot();

    // Back-pressure: result held for 5 cycles, then retire and accept together.
    out_ready = 1'b0;
    do_op(16'hF0F0, 16'hFF00, 4'd1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      check("t4_hold", 64'({in_ready, outs()}),
            64'({1'b0, 1'b1, 16'hF000, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
    end
    to_slot();
    out_ready = 1'b1;
    do_op(16'h1234, 16'h00FF, 4'd3, 1'b1, 1'b0, 1'b0);
    @(negedge clk);
    check("t4_xor", 64'(outs()), 64'({1'b1, 16'h12CB, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
    to_slot();

`ifdef ALU_SEQ_MUL_EN
    // Multiply latency and busy window.
    do_op(16'h00FF, 16'h0101, 4'd7, 1'b0, 1'b0, 1'b0);
    for (int i = 1; i <= 17; i++) begin
      @(negedge clk);
      if (i <= 16) check("t3_busy", 64'({out_valid, in_ready}), 64'(0));
      else check("t3_mul", 64'(outs()), 64'({1'b1, 16'hFFFF, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0}));
    end
    to_slot();

    // Reset mid-multiply.
    do_op(16'h0003, 16'h0005, 4'd7, 1'b0, 1'b0, 1'b0);
    repeat (6) @(posedge clk);
    #1 rst_n = 1'b0;
    #1;
    check("t5_reset_outs", 64'(outs()), 64'(0));
    check("t5_reset_ready", 64'(in_ready), 64'(1));
    to_slot();
    rst_n = 1'b1;
    for (int i = 0; i < 24; i++) begin
      @(negedge clk);
      check("t5_no_stale", 64'(out_valid), 64'(0));
    end
    to_slot();
`else
    // Opcode 7 is reserved without the multiplier.
    do_op(16'h00FF, 16'h0101, 4'd7, 1'b0, 1'b0, 1'b0);
    @(negedge clk);
    check("t3_mul_reserved", 64'(outs()), 64'({1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1}));
    to_slot();

    // Reset while a result is held.
    out_ready = 1'b0;
    do_op(16'h0005, 16'h0005, 4'd0, 1'b0, 1'b0, 1'b0);
    #1 rst_n = 1'b0;
    #1;
    check("t5_reset_outs", 64'(outs()), 64'(0));
    check("t5_reset_ready", 64'(in_ready), 64'(1));
    to_slot();
    rst_n = 1'b1;
    out_ready = 1'b1;
    for (int i = 0; i < 4; i++) begin
      @(negedge clk);
      check("t5_no_stale", 64'(out_valid), 64'(0));
    end
    to_slot();
`endif

    // Opcode sweep with random back-pressure; checked by the per-cycle model.
    for (int i = 0; i < 32; i++) begin
      do_op(16'($urandom), 16'($urandom), 4'(i % 16), 1'(i / 16), 1'($urandom_range(0, 1)), 1'b1);
    end
    for (int i = 0; i < 40; i++) begin
      do_op(16'($urandom), 16'($urandom), 4'($urandom_range(0, 9)), 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), 1'b1);
    end
    out_ready = 1'b1;
    repeat (24) @(posedge clk);
    #1;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
